// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC datapath ALU.
//  - default operand and shift-amount widths
//  - ALU operation encodings used on the 2-bit op field
package cordic_pkg;

  localparam int unsigned DEFAULT_WORD_WIDTH  = 16;
  localparam int unsigned DEFAULT_SHIFT_WIDTH = 5;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_SUB    = 2'd1,
    OP_NOP    = 2'd2,
    OP_ADDSUB = 2'd3
  } alu_op_e;

endpackage

// File: rtl/cordic_alu_core.sv
// Combinational CORDIC ALU: A +/- (B >>> shamt), with overflow detection and optional
// saturation.
// Ports:
//  op        in   2            operation (see cordic_pkg)
//  dir       in   1            OP_ADDSUB direction: 0 add, 1 subtract
//  shamt     in   SHIFT_WIDTH  arithmetic right shift applied to b
//  a, b      in   WORD_WIDTH   signed operands
//  result    out  WORD_WIDTH   signed result (clamped or wrapped)
//  overflow  out  1            exact result outside the signed WORD_WIDTH range
module cordic_alu_core
  import cordic_pkg::*;
#(
  parameter int unsigned WORD_WIDTH  = DEFAULT_WORD_WIDTH,
  parameter int unsigned SHIFT_WIDTH = DEFAULT_SHIFT_WIDTH,
  parameter int unsigned SATURATE    = 1
) (
  input  logic [1:0]             op,
  input  logic                   dir,
  input  logic [SHIFT_WIDTH-1:0] shamt,
  input  logic [WORD_WIDTH-1:0]  a,
  input  logic [WORD_WIDTH-1:0]  b,
  output logic [WORD_WIDTH-1:0]  result,
  output logic                   overflow
);

  // Two guard bits hold every A +/- Bs exactly, including 0 - (most negative).
  localparam int unsigned XW = WORD_WIDTH + 2;

  logic [WORD_WIDTH-1:0] bs;
  logic [XW-1:0]         a_x;
  logic [XW-1:0]         bs_x;
  logic [XW-1:0]         exact;
  logic                  subtract;
  logic                  out_of_range;

  always_comb begin
    // Oversized shifts collapse to the sign fill of b.
    if (32'(shamt) >= WORD_WIDTH) begin
      bs = {WORD_WIDTH{b[WORD_WIDTH-1]}};
    end else begin
      bs = $signed(b) >>> shamt;
    end

    a_x      = {{2{a[WORD_WIDTH-1]}}, a};
    bs_x     = {{2{bs[WORD_WIDTH-1]}}, bs};
    subtract = (op == OP_SUB) || ((op == OP_ADDSUB) && dir);
    exact    = subtract ? (a_x - bs_x) : (a_x + bs_x);

    // In range iff the guard bits and the result sign bit all agree.
    out_of_range = (exact[XW-1:WORD_WIDTH-1] != '0) && (exact[XW-1:WORD_WIDTH-1] != '1);

    if (op == OP_NOP) begin
      result   = a;
      overflow = 1'b0;
    end else if (out_of_range && (SATURATE != 0)) begin
      result   = exact[XW-1] ? {1'b1, {(WORD_WIDTH-1){1'b0}}} : {1'b0, {(WORD_WIDTH-1){1'b1}}};
      overflow = 1'b1;
    end else begin
      result   = exact[WORD_WIDTH-1:0];
      overflow = out_of_range;
    end
  end

endmodule

// File: rtl/cordic_alu_pipe.sv
// Pipelined CORDIC ALU with valid/ready handshake and a global stall.
// Stage 1 registers the ALU output; later stages are pure delay.
// Ports:
//  clk, rst              clock (rising edge), asynchronous active-high reset
//  in_valid / in_ready   input handshake; accept = in_valid & in_ready
//  op, dir, shamt, A, B  operation, ADDSUB direction, shift of B, signed operands
//  out_valid / out_ready output handshake
//  result, overflow      signed result and overflow flag, held while not valid
module cordic_alu_pipe
  import cordic_pkg::*;
#(
  parameter int unsigned WORD_WIDTH  = DEFAULT_WORD_WIDTH,
  parameter int unsigned SHIFT_WIDTH = DEFAULT_SHIFT_WIDTH,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned SATURATE    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic                   dir,
  input  logic [SHIFT_WIDTH-1:0] shamt,
  input  logic [WORD_WIDTH-1:0]  A,
  input  logic [WORD_WIDTH-1:0]  B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_WIDTH-1:0]  result,
  output logic                   overflow
);

  logic [WORD_WIDTH-1:0] alu_result;
  logic                  alu_overflow;
  logic                  advance;

  logic                  stg_vld [PIPE_STAGES];
  logic [WORD_WIDTH-1:0] stg_res [PIPE_STAGES];
  logic                  stg_ovf [PIPE_STAGES];

  cordic_alu_core #(
    .WORD_WIDTH (WORD_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH),
    .SATURATE   (SATURATE)
  ) u_core (
    .op      (op),
    .dir     (dir),
    .shamt   (shamt),
    .a       (A),
    .b       (B),
    .result  (alu_result),
    .overflow(alu_overflow)
  );

  // Whole pipeline moves together; the output slot frees up as it is consumed.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    logic                  src_vld;
    logic [WORD_WIDTH-1:0] src_res;
    logic                  src_ovf;
    logic                  vld_q;
    logic [WORD_WIDTH-1:0] res_q;
    logic                  ovf_q;

    if (s == 0) begin : g_head
      assign src_vld = in_valid;
      assign src_res = alu_result;
      assign src_ovf = alu_overflow;
    end else begin : g_body
      assign src_vld = stg_vld[s-1];
      assign src_res = stg_res[s-1];
      assign src_ovf = stg_ovf[s-1];
    end

    // Data loads only with a valid entry so the output holds its last result across bubbles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        res_q <= '0;
        ovf_q <= 1'b0;
      end else if (advance) begin
        vld_q <= src_vld;
        if (src_vld) begin
          res_q <= src_res;
          ovf_q <= src_ovf;
        end
      end
    end

    assign stg_vld[s] = vld_q;
    assign stg_res[s] = res_q;
    assign stg_ovf[s] = ovf_q;
  end

  assign out_valid = stg_vld[PIPE_STAGES-1];
  assign result    = stg_res[PIPE_STAGES-1];
  assign overflow  = stg_ovf[PIPE_STAGES-1];

endmodule

// File: tb/tb_cordic_alu_pipe.sv
// Self-checking bench for cordic_alu_pipe. Four lanes with different configurations:
//  lane 0: 2 stages, saturating   lane 1: 2 stages, wrapping
//  lane 2: 1 stage,  saturating   lane 3: 4 stages, wrapping
// Stimulus pushes expected {overflow, result} into a per-lane queue on accept; one
// monitor pops and compares whenever a lane presents a valid output.
module tb_cordic_alu_pipe;

  localparam int W  = 16;
  localparam int SW = 5;
  localparam int NL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid  [NL];
  logic          in_ready  [NL];
  logic [1:0]    op        [NL];
  logic          dir       [NL];
  logic [SW-1:0] shamt     [NL];
  logic [W-1:0]  a         [NL];
  logic [W-1:0]  b         [NL];
  logic          out_valid [NL];
  logic          out_ready [NL];
  logic [W-1:0]  result    [NL];
  logic          overflow  [NL];
  bit            rand_rdy  [NL];

  logic [W:0] exp_q [NL][$];
  logic [W:0] last  [NL];
  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    cordic_alu_pipe #(
      .WORD_WIDTH (W),
      .SHIFT_WIDTH(SW),
      .PIPE_STAGES((g == 2) ? 1 : ((g == 3) ? 4 : 2)),
      .SATURATE   ((g == 0 || g == 2) ? 1 : 0)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .op       (op[g]),
      .dir      (dir[g]),
      .shamt    (shamt[g]),
      .A        (a[g]),
      .B        (b[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .result   (result[g]),
      .overflow (overflow[g])
    );
  end

  function automatic int lane_sat(int l);
    return (l == 0 || l == 2) ? 1 : 0;
  endfunction

  // Reference: integer arithmetic on the mathematical definition.
  function automatic logic [W:0] model(int sat, int o, int d, int s, logic [W-1:0] av,
                                       logic [W-1:0] bv);
    int ai;
    int bi;
    int bsv;
    int ex;
    int maxv;
    int minv;
    bit ov;
    logic [W-1:0] r;
    ai   = $signed(av);
    bi   = $signed(bv);
    maxv = (1 << (W - 1)) - 1;
    minv = -(1 << (W - 1));
    if (s >= W) begin
      bsv = (bi < 0) ? -1 : 0;
    end else begin
      bsv = bi / (1 << s);
      if (bi < 0 && (bi % (1 << s)) != 0) bsv = bsv - 1;
    end
    case (o)
      0:       ex = ai + bsv;
      1:       ex = ai - bsv;
      2:       ex = ai;
      default: ex = (d != 0) ? (ai - bsv) : (ai + bsv);
    endcase
    ov = (ex > maxv) || (ex < minv);
    if (ov && sat != 0) r = (ex > 0) ? W'(maxv) : W'(minv);
    else                r = ex[W-1:0];
    return {ov, r};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(int l, logic [1:0] o, logic d, logic [SW-1:0] s, logic [W-1:0] av,
                      logic [W-1:0] bv, logic [W:0] e);
    int waited;
    in_valid[l] = 1'b1;
    op[l]       = o;
    dir[l]      = d;
    shamt[l]    = s;
    a[l]        = av;
    b[l]        = bv;
    waited      = 0;
    @(negedge clk);
    while (!in_ready[l] && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready[l]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout lane %0d: in_ready got 0 required 1", l);
    end else begin
      exp_q[l].push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid[l] = 1'b0;
  endtask

  task automatic drain(int l);
    int k;
    k = 0;
    while (exp_q[l].size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("drain_lane%0d", l), exp_q[l].size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic run_random(int l, int n);
    for (int i = 0; i < n; i++) begin
      logic [1:0]    o;
      logic          d;
      logic [SW-1:0] s;
      logic [W-1:0]  av;
      logic [W-1:0]  bv;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      o  = 2'($urandom_range(0, 3));
      d  = 1'($urandom_range(0, 1));
      s  = SW'($urandom_range(0, 31));
      av = pick_val();
      bv = pick_val();
      send(l, o, d, s, av, bv, model(lane_sat(l), int'(o), int'(d), int'(s), av, bv));
    end
    drain(l);
  endtask

  always @(posedge clk) begin
    #1;
    for (int l = 0; l < NL; l++) begin
      if (rand_rdy[l]) out_ready[l] = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: handshake relation, in-order result check, hold while stalled or idle.
  always @(negedge clk) begin
    if (rst) begin
      for (int l = 0; l < NL; l++) last[l] = '0;
    end else begin
      for (int l = 0; l < NL; l++) begin
        n_cmp++;
        if (in_ready[l] !== (!out_valid[l] || out_ready[l])) begin
          n_bad++;
          $display("FAIL in_ready lane %0d: got %0b with out_valid %0b out_ready %0b", l,
                   in_ready[l], out_valid[l], out_ready[l]);
        end
        n_cmp++;
        if (out_valid[l]) begin
          if (exp_q[l].size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output lane %0d: got %0h with empty queue", l,
                     {overflow[l], result[l]});
          end else begin
            if ({overflow[l], result[l]} !== exp_q[l][0]) begin
              n_bad++;
              $display("FAIL result lane %0d: got %0h expected %0h at %0t", l,
                       {overflow[l], result[l]}, exp_q[l][0], $time);
            end
            if (out_ready[l]) begin
              last[l] = exp_q[l][0];
              void'(exp_q[l].pop_front());
            end
          end
        end else if ({overflow[l], result[l]} !== last[l]) begin
          n_bad++;
          $display("FAIL idle_hold lane %0d: got %0h expected %0h at %0t", l,
                   {overflow[l], result[l]}, last[l], $time);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int l = 0; l < NL; l++) begin
      in_valid[l]  = 1'b0;
      op[l]        = 2'd0;
      dir[l]       = 1'b0;
      shamt[l]     = '0;
      a[l]         = '0;
      b[l]         = '0;
      out_ready[l] = 1'b1;
      rand_rdy[l]  = 1'b0;
      last[l]      = '0;
    end
    #3;
    for (int l = 0; l < NL; l++) begin
      check($sformatf("reset_valid_lane%0d", l), out_valid[l], 0);
      check($sformatf("reset_result_lane%0d", l), {overflow[l], result[l]}, 0);
    end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Positive overflow: clamp vs wrap, and two-cycle latency.
    fork
      send(0, 2'd0, 1'b0, 5'd0, 16'h7000, 16'h2000, 17'h1_7FFF);
      send(1, 2'd0, 1'b0, 5'd0, 16'h7000, 16'h2000, 17'h1_9000);
    join
    @(negedge clk);
    check("latency_early_lane0", out_valid[0], 0);
    check("latency_early_lane1", out_valid[1], 0);
    @(negedge clk);
    check("latency_due_lane0", out_valid[0], 1);
    check("latency_due_lane1", out_valid[1], 1);
    @(posedge clk);
    #1;

    // Shifted operands, ADDSUB direction, extreme cases, NOP.
    send(0, 2'd1, 1'b0, 5'd3, 16'd100, 16'hFFC0, 17'h0_006C);
    send(0, 2'd3, 1'b0, 5'd2, 16'd10, 16'd40, 17'h0_0014);
    send(0, 2'd3, 1'b1, 5'd2, 16'd10, 16'd40, 17'h0_0000);
    send(0, 2'd1, 1'b0, 5'd0, 16'h0000, 16'h8000, 17'h1_7FFF);
    send(0, 2'd0, 1'b0, 5'd20, 16'h0000, 16'hFFFB, 17'h0_FFFF);
    send(0, 2'd2, 1'b1, 5'd5, 16'h8000, 16'h7FFF, 17'h0_8000);
    send(0, 2'd0, 1'b0, 5'd0, 16'h8000, 16'h8000, 17'h1_8000);
    send(1, 2'd1, 1'b0, 5'd0, 16'h0000, 16'h8000, 17'h1_8000);
    send(1, 2'd0, 1'b0, 5'd31, 16'h7FFF, 16'h8001, 17'h0_7FFE);
    drain(0);
    drain(1);

    // Back-to-back with a three-cycle output stall.
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          send(0, 2'd0, 1'b0, 5'd0, W'(i * 3), 16'd1, 17'(i * 3 + 1));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
      end
    join
    drain(0);

    // Asynchronous reset with two operations in flight.
    out_ready[0] = 1'b0;
    send(0, 2'd0, 1'b0, 5'd0, 16'd5, 16'd5, 17'd10);
    send(0, 2'd0, 1'b0, 5'd0, 16'd7, 16'd7, 17'd14);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_valid", out_valid[0], 0);
    check("async_reset_result", {overflow[0], result[0]}, 0);
    for (int l = 0; l < NL; l++) exp_q[l].delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_valid", out_valid[0], 0);
    send(0, 2'd0, 1'b0, 5'd0, 16'd1, 16'd1, 17'd2);
    @(negedge clk);
    check("post_reset_latency_early", out_valid[0], 0);
    @(negedge clk);
    check("post_reset_latency_due", out_valid[0], 1);
    check("post_reset_value", {overflow[0], result[0]}, 17'd2);
    @(posedge clk);
    #1;

    // Randomized traffic with random back-pressure on every lane.
    for (int l = 0; l < NL; l++) rand_rdy[l] = 1'b1;
    fork
      run_random(0, 300);
      run_random(1, 300);
      run_random(2, 300);
      run_random(3, 300);
    join
    for (int l = 0; l < NL; l++) begin
      rand_rdy[l]  = 1'b0;
      out_ready[l] = 1'b1;
    end
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
